// File: rtl/aximm_test_sequencer.sv
// Autonomous write-then-read-back test sequencer for the AXI-MM loopback path.
// Waits for link_online, then runs cfg_num_iter iterations of
// write strobe / write completion / read strobe / read completion / checker
// verdict, and accumulates pass/fail counts. Every wait state is bounded by
// TIMEOUT; an expired wait aborts the run with timeout_err set.
module aximm_test_sequencer #(
  parameter int unsigned          ADDRWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0] ADDR_STEP = ADDRWIDTH'(32'h0000_0100),
  parameter int unsigned          TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           cfg_num_iter,
  input  logic [7:0]           cfg_length,
  input  logic [1:0]           cfg_burst,
  input  logic [2:0]           cfg_size,
  input  logic [ADDRWIDTH-1:0] cfg_base_addr,
  input  logic                 link_online,
  input  logic                 write_complete,
  input  logic                 read_complete,
  input  logic [1:0]           chkr_pass,
  output logic                 aximm_wr,
  output logic                 aximm_rd,
  output logic [7:0]           aximm_rw_length,
  output logic [1:0]           aximm_rw_burst,
  output logic [2:0]           aximm_rw_size,
  output logic [ADDRWIDTH-1:0] aximm_rw_addr,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           pass_cnt,
  output logic [7:0]           fail_cnt,
  output logic                 timeout_err,
  output logic [2:0]           state_dbg
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  // The abort is decided one cycle early so that the counter reaches
  // TIMEOUT-1 on the same edge that enters DONE.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ONL = 3'd1,
    WR_ISSUE = 3'd2,
    WR_WAIT  = 3'd3,
    RD_ISSUE = 3'd4,
    RD_WAIT  = 3'd5,
    CHECK    = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [7:0]    num_iter;
  logic [7:0]    iter_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          tmo_abort;
  logic          wr_cpl_q;
  logic          rd_cpl_q;

  assign state_dbg = state;

  // Next-state decode, including timeout aborts out of the wait states.
  always_comb begin
    next_state = state;
    tmo_abort  = 1'b0;
    tmo_hit    = (tmo_cnt == TMO_LAST);
    case (state)
      IDLE: begin
        if (start) next_state = (cfg_num_iter == 8'd0) ? DONE : WAIT_ONL;
      end
      WAIT_ONL: begin
        if (link_online) next_state = WR_ISSUE;
        else if (tmo_hit) begin
          next_state = DONE;
          tmo_abort  = 1'b1;
        end
      end
      WR_ISSUE: next_state = WR_WAIT;
      WR_WAIT: begin
        if (wr_cpl_q) next_state = RD_ISSUE;
        else if (tmo_hit) begin
          next_state = DONE;
          tmo_abort  = 1'b1;
        end
      end
      RD_ISSUE: next_state = RD_WAIT;
      RD_WAIT: begin
        if (rd_cpl_q) next_state = CHECK;
        else if (tmo_hit) begin
          next_state = DONE;
          tmo_abort  = 1'b1;
        end
      end
      CHECK: begin
        if (chkr_pass[1]) next_state = ((iter_cnt + 8'd1) == num_iter) ? DONE : WAIT_ONL;
        else if (tmo_hit) begin
          next_state = DONE;
          tmo_abort  = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Registered outputs, run configuration, counters and completion capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aximm_wr        <= 1'b0;
      aximm_rd        <= 1'b0;
      aximm_rw_length <= '0;
      aximm_rw_burst  <= '0;
      aximm_rw_size   <= '0;
      aximm_rw_addr   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      timeout_err     <= 1'b0;
      num_iter        <= '0;
      iter_cnt        <= '0;
      tmo_cnt         <= '0;
      wr_cpl_q        <= 1'b0;
      rd_cpl_q        <= 1'b0;
    end else begin
      // Strobes and status are decoded from next_state so they are true
      // register outputs aligned with the state they belong to.
      aximm_wr <= (next_state == WR_ISSUE);
      aximm_rd <= (next_state == RD_ISSUE);
      done     <= (next_state == DONE);
      busy     <= (next_state != IDLE);

      // Completions only count while their consuming state is active.
      wr_cpl_q <= write_complete && (state == WR_WAIT);
      rd_cpl_q <= read_complete && (state == RD_WAIT);

      if (state == IDLE || next_state != state) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + 1'b1;

      if (state == IDLE && start) begin
        num_iter        <= cfg_num_iter;
        aximm_rw_length <= cfg_length;
        aximm_rw_burst  <= cfg_burst;
        aximm_rw_size   <= cfg_size;
        aximm_rw_addr   <= cfg_base_addr;
        iter_cnt        <= '0;
        pass_cnt        <= '0;
        fail_cnt        <= '0;
        timeout_err     <= 1'b0;
      end

      if (state == CHECK && chkr_pass[1]) begin
        if (chkr_pass[0]) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 8'd1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 8'd1;
        end
        aximm_rw_addr <= aximm_rw_addr + ADDR_STEP;
        iter_cnt      <= iter_cnt + 8'd1;
      end

      if (tmo_abort) begin
        timeout_err <= 1'b1;
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_aximm_test_sequencer.sv
// Self-checking bench for aximm_test_sequencer: directed vector table,
// randomized runs against an iteration-level reference model, and
// hand-written timeout / gating / ignored-start / reset sequences.
module tb_aximm_test_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_num_iter;
  logic [7:0]  cfg_length;
  logic [1:0]  cfg_burst;
  logic [2:0]  cfg_size;
  logic [31:0] cfg_base_addr;
  logic        link_online;
  logic        write_complete;
  logic        read_complete;
  logic [1:0]  chkr_pass;

  logic        d_wr, d_rd, d_busy, d_done, d_tmo;
  logic [7:0]  d_len, d_pass, d_fail;
  logic [1:0]  d_burst;
  logic [2:0]  d_size, d_state;
  logic [31:0] d_addr;

  logic        t_wr, t_rd, t_busy, t_done, t_tmo;
  logic [7:0]  t_len, t_pass, t_fail;
  logic [1:0]  t_burst;
  logic [2:0]  t_size, t_state;
  logic [31:0] t_addr;

  aximm_test_sequencer #(
    .ADDRWIDTH (32),
    .ADDR_STEP (32'h0000_0100),
    .TIMEOUT   (256)
  ) u_dut (
    .clk (clk), .rst (rst), .start (start),
    .cfg_num_iter (cfg_num_iter), .cfg_length (cfg_length), .cfg_burst (cfg_burst),
    .cfg_size (cfg_size), .cfg_base_addr (cfg_base_addr), .link_online (link_online),
    .write_complete (write_complete), .read_complete (read_complete), .chkr_pass (chkr_pass),
    .aximm_wr (d_wr), .aximm_rd (d_rd), .aximm_rw_length (d_len), .aximm_rw_burst (d_burst),
    .aximm_rw_size (d_size), .aximm_rw_addr (d_addr), .busy (d_busy), .done (d_done),
    .pass_cnt (d_pass), .fail_cnt (d_fail), .timeout_err (d_tmo), .state_dbg (d_state)
  );

  aximm_test_sequencer #(
    .ADDRWIDTH (32),
    .ADDR_STEP (32'h0000_0100),
    .TIMEOUT   (16)
  ) u_dut_t16 (
    .clk (clk), .rst (rst), .start (start),
    .cfg_num_iter (cfg_num_iter), .cfg_length (cfg_length), .cfg_burst (cfg_burst),
    .cfg_size (cfg_size), .cfg_base_addr (cfg_base_addr), .link_online (link_online),
    .write_complete (write_complete), .read_complete (read_complete), .chkr_pass (chkr_pass),
    .aximm_wr (t_wr), .aximm_rd (t_rd), .aximm_rw_length (t_len), .aximm_rw_burst (t_burst),
    .aximm_rw_size (t_size), .aximm_rw_addr (t_addr), .busy (t_busy), .done (t_done),
    .pass_cnt (t_pass), .fail_cnt (t_fail), .timeout_err (t_tmo), .state_dbg (t_state)
  );

  // Observed instance: the short-timeout copy is only selected for the timeout test.
  bit          sel_t;
  logic        m_wr, m_rd, m_busy, m_done, m_tmo;
  logic [7:0]  m_len, m_pass, m_fail;
  logic [1:0]  m_burst;
  logic [2:0]  m_size, m_state;
  logic [31:0] m_addr;
  assign m_wr    = sel_t ? t_wr    : d_wr;
  assign m_rd    = sel_t ? t_rd    : d_rd;
  assign m_busy  = sel_t ? t_busy  : d_busy;
  assign m_done  = sel_t ? t_done  : d_done;
  assign m_tmo   = sel_t ? t_tmo   : d_tmo;
  assign m_len   = sel_t ? t_len   : d_len;
  assign m_pass  = sel_t ? t_pass  : d_pass;
  assign m_fail  = sel_t ? t_fail  : d_fail;
  assign m_burst = sel_t ? t_burst : d_burst;
  assign m_size  = sel_t ? t_size  : d_size;
  assign m_state = sel_t ? t_state : d_state;
  assign m_addr  = sel_t ? t_addr  : d_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion responder: emulates leader/follower apps and the pattern checker.
  int         wr_lat, rd_lat, chk_lat;
  int         wc_t, rc_t, ck_t;
  logic [7:0] verdicts;
  logic [2:0] v_idx;
  bit         rd_en;
  initial begin
    write_complete = 1'b0;
    read_complete  = 1'b0;
    chkr_pass      = 2'b00;
    wc_t = 0; rc_t = 0; ck_t = 0;
    forever begin
      @(negedge clk);
      write_complete = 1'b0;
      read_complete  = 1'b0;
      chkr_pass      = 2'b00;
      if (wc_t > 0) begin
        if (wc_t == 1) write_complete = 1'b1;
        wc_t--;
      end
      if (ck_t > 0) begin
        if (ck_t == 1) begin
          chkr_pass = {1'b1, verdicts[v_idx]};
          v_idx     = v_idx + 3'd1;
        end
        ck_t--;
      end
      if (rc_t > 0) begin
        if (rc_t == 1 && rd_en) begin
          read_complete = 1'b1;
          ck_t          = chk_lat;
        end
        rc_t--;
      end
      if (m_wr) wc_t = wr_lat;
      if (m_rd) rc_t = rd_lat;
    end
  end

  // Monitor: strobe counts, write-strobe addresses, done timing, field stability.
  logic [31:0] wr_addr_q[$];
  int          wr_cnt, rd_cnt, done_cnt, done_cyc, wr_first_cyc;
  bit          stable_ok;
  logic [44:0] prev_fields;
  initial begin
    prev_fields = '0;
    forever begin
      @(negedge clk);
      if (m_wr) begin
        if (wr_cnt == 0) wr_first_cyc = cyc;
        wr_cnt++;
        wr_addr_q.push_back(m_addr);
        if ({m_addr, m_len, m_burst, m_size} !== prev_fields) stable_ok = 1'b0;
      end
      if (m_rd) rd_cnt++;
      if (m_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_fields = {m_addr, m_len, m_burst, m_size};
    end
  end

  task automatic do_run(input int n, input logic [31:0] base, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size,
                        input int wl, input int rl, input int cl, input logic [7:0] verdict,
                        input int stray_at, input int link_at, output int t0);
    bit seen;
    int k;
    wr_lat = wl; rd_lat = rl; chk_lat = cl;
    verdicts = verdict;
    v_idx = '0;
    @(negedge clk);
    wr_addr_q.delete();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_cyc = 0; wr_first_cyc = 0;
    stable_ok = 1'b1;
    cfg_num_iter  = 8'(n);
    cfg_base_addr = base;
    cfg_length    = len;
    cfg_burst     = burst;
    cfg_size      = size;
    link_online   = (link_at == 0);
    start         = 1'b1;
    t0            = cyc;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(m_busy), 64'd1);
    check("start_state", 64'(m_state), (n == 0) ? 64'd7 : 64'd1);
    seen = m_done;
    k = 0;
    while (!seen && k < 4000) begin
      @(negedge clk);
      k++;
      start = (stray_at > 0) && (cyc == t0 + stray_at);
      if (start) begin
        cfg_num_iter  = 8'd9;
        cfg_base_addr = 32'hDEAD_0000;
        cfg_length    = 8'hEE;
      end
      if (link_at > 0 && cyc == t0 + link_at) link_online = 1'b1;
      seen = m_done;
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int t0, input int n, input int e_pass,
                           input int e_fail, input int e_done, input logic [31:0] e_first,
                           input logic [31:0] e_last, input logic [31:0] e_final,
                           input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
    logic [63:0] a_first, a_last;
    a_first = (wr_addr_q.size() > 0) ? 64'(wr_addr_q[0]) : 64'hDEAD_DEAD_DEAD_DEAD;
    a_last  = (wr_addr_q.size() > 0) ? 64'(wr_addr_q[$]) : 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, "_wr_cnt"},   64'(wr_cnt), 64'(n));
    check({tag, "_rd_cnt"},   64'(rd_cnt), 64'(n));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_dly"}, 64'(done_cyc - t0), 64'(e_done));
    check({tag, "_pass"},     64'(m_pass), 64'(e_pass));
    check({tag, "_fail"},     64'(m_fail), 64'(e_fail));
    check({tag, "_tmo"},      64'(m_tmo), 64'd0);
    check({tag, "_busy_end"}, 64'(m_busy), 64'd0);
    check({tag, "_idle_end"}, 64'(m_state), 64'd0);
    check({tag, "_addr_end"}, 64'(m_addr), 64'(e_final));
    check({tag, "_fields"},   64'({m_len, m_burst, m_size}), 64'({len, burst, size}));
    if (n > 0) begin
      check({tag, "_addr_first"}, a_first, 64'(e_first));
      check({tag, "_addr_last"},  a_last, 64'(e_last));
      check({tag, "_stable"},     64'(stable_ok), 64'd1);
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] base;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    int          wl, rl, cl;
    logic [7:0]  verdict;
    int          e_pass, e_fail, e_done;
    logic [31:0] e_first, e_last, e_final;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int t0;
    int nonidle;
    bit seen3;
    n_checks = 0; n_fail = 0;
    sel_t = 1'b0; rd_en = 1'b1;
    wr_lat = 5; rd_lat = 5; chk_lat = 2; verdicts = '0; v_idx = '0;
    start = 1'b0; cfg_num_iter = '0; cfg_length = '0; cfg_burst = '0; cfg_size = '0;
    cfg_base_addr = '0; link_online = 1'b1;
    rst = 1'b1;

    //            n  base           len    bu    sz    wl rl cl verdict e_p e_f done first          last           final
    vecs[0] = '{3, 32'h0000_1000, 8'h0F, 2'd1, 3'd2, 5, 5, 2, 8'h07,  3,  0,  49, 32'h0000_1000, 32'h0000_1200, 32'h0000_1300};
    vecs[1] = '{4, 32'h0000_2000, 8'h03, 2'd1, 3'd3, 3, 2, 2, 8'h05,  2,  2,  45, 32'h0000_2000, 32'h0000_2300, 32'h0000_2400};
    vecs[2] = '{0, 32'h0000_4000, 8'h07, 2'd2, 3'd1, 5, 5, 2, 8'h00,  0,  0,   1, 32'h0000_0000, 32'h0000_0000, 32'h0000_4000};
    vecs[3] = '{2, 32'hFFFF_FF80, 8'h01, 2'd0, 3'd4, 1, 1, 2, 8'h03,  2,  0,  17, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0180};
    vecs[4] = '{1, 32'hABCD_0000, 8'hFF, 2'd1, 3'd0, 7, 4, 3, 8'h00,  0,  1,  19, 32'hABCD_0000, 32'hABCD_0000, 32'hABCD_0100};

    repeat (2) @(negedge clk);
    check("rst_ctrl", 64'({d_wr, d_rd, d_busy, d_done, d_tmo, d_state}), 64'd0);
    check("rst_cnt",  64'({d_pass, d_fail}), 64'd0);
    check("rst_rw",   64'({d_len, d_burst, d_size, d_addr}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 5; i++) begin
      do_run(vecs[i].n, vecs[i].base, vecs[i].len, vecs[i].burst, vecs[i].size,
             vecs[i].wl, vecs[i].rl, vecs[i].cl, vecs[i].verdict, 0, 0, t0);
      check_run($sformatf("vec%0d", i), t0, vecs[i].n, vecs[i].e_pass, vecs[i].e_fail,
                vecs[i].e_done, vecs[i].e_first, vecs[i].e_last, vecs[i].e_final,
                vecs[i].len, vecs[i].burst, vecs[i].size);
    end

    // Randomized runs against the iteration-level model.
    for (int r = 0; r < 25; r++) begin
      int n, wl, rl, cl, e_pass, per_iter;
      logic [31:0] base;
      logic [7:0]  verdict, len;
      logic [1:0]  burst;
      logic [2:0]  size;
      n       = int'($urandom_range(6, 1));
      wl      = int'($urandom_range(8, 1));
      rl      = int'($urandom_range(8, 1));
      cl      = int'($urandom_range(5, 2));
      base    = $urandom;
      verdict = 8'($urandom);
      len     = 8'($urandom);
      burst   = 2'($urandom);
      size    = 3'($urandom);
      e_pass = 0;
      for (int i = 0; i < n; i++) if (verdict[i]) e_pass++;
      // write latency + 2 to read strobe, read latency, checker latency, 2-cycle gap
      per_iter = wl + 2 + rl + cl + 2;
      do_run(n, base, len, burst, size, wl, rl, cl, verdict, 0, 0, t0);
      check_run($sformatf("rnd%0d", r), t0, n, e_pass, n - e_pass, 1 + n * per_iter,
                base, base + 32'(n - 1) * 32'h100, base + 32'(n) * 32'h100, len, burst, size);
    end

    // Start pulsed while busy is ignored: same counts, addresses and cfg.
    do_run(2, 32'h0000_3000, 8'h11, 2'd1, 3'd2, 5, 5, 2, 8'h03, 6, 0, t0);
    check_run("ign_start", t0, 2, 2, 0, 33, 32'h0000_3000, 32'h0000_3100, 32'h0000_3200,
              8'h11, 2'd1, 3'd2);

    // Link gating: write strobe one cycle after link_online rises.
    do_run(1, 32'h0000_5000, 8'h02, 2'd1, 3'd2, 5, 5, 2, 8'h01, 0, 51, t0);
    check("gate_wr_cyc", 64'(wr_first_cyc - t0), 64'd52);
    check_run("gate", t0, 1, 1, 0, 67, 32'h0000_5000, 32'h0000_5000, 32'h0000_5100,
              8'h02, 2'd1, 3'd2);

    // Timeout (TIMEOUT=16 instance): read completion withheld on iteration 1 of 2.
    sel_t = 1'b1;
    rd_en = 1'b0;
    do_run(2, 32'h0000_6000, 8'h00, 2'd1, 3'd2, 5, 5, 2, 8'h03, 0, 0, t0);
    check("tmo_err",      64'(m_tmo), 64'd1);
    check("tmo_fail",     64'(m_fail), 64'd1);
    check("tmo_pass",     64'(m_pass), 64'd0);
    check("tmo_done_dly", 64'(done_cyc - t0), 64'd25);
    check("tmo_wr_cnt",   64'(wr_cnt), 64'd1);
    check("tmo_done_cnt", 64'(done_cnt), 64'd1);
    check("tmo_busy_end", 64'(m_busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sel_t = 1'b0;
    rd_en = 1'b1;
    wc_t = 0; rc_t = 0; ck_t = 0;
    repeat (2) @(negedge clk);

    // Asynchronous reset during WR_WAIT; late write_complete must be ignored.
    wr_lat = 30;
    cfg_num_iter = 8'd2; cfg_base_addr = 32'h0000_7000; cfg_length = 8'h05;
    cfg_burst = 2'd1; cfg_size = 3'd2; link_online = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen3 = 1'b0;
    for (int k = 0; k < 20 && !seen3; k++) begin
      @(negedge clk);
      seen3 = (d_state == 3'd3);
    end
    check("rstm_reach_wrwait", 64'(seen3), 64'd1);
    rst = 1'b1;
    #1;
    check("rstm_ctrl", 64'({d_wr, d_rd, d_busy, d_done, d_tmo, d_state, d_pass, d_fail}), 64'd0);
    check("rstm_rw",   64'({d_len, d_burst, d_size, d_addr}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nonidle = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_state != 3'd0 || d_busy || d_wr || d_rd || d_done) nonidle++;
    end
    check("rstm_stays_idle", 64'(nonidle), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aximm_test_sequencer.md
# aximm_test_sequencer

Autonomous test sequencer for the AXI-MM leader/follower loopback datapath. It replaces manual CSR pokes: it waits for the link to come online, then runs a programmable number of write-then-read-back iterations. For each iteration it drives the leader app's write/read command strobes and transfer descriptor, waits for the completion flags, and samples the pattern-checker verdict. It sits beside the CSR block in the top level and accumulates pass/fail statistics.

## Interface
Parameters:
- ADDRWIDTH, 32, width of the transfer address.
- ADDR_STEP, 32'h0000_0100, address increment applied between iterations.
- TIMEOUT, 4096, maximum cycles spent in any wait state; must be ≥ 2.

Ports:
- clk  in  1  single clock; all logic in this domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a run; ignored while busy=1.
- cfg_num_iter  in  8  iterations per run, sampled at start.
- cfg_length  in  8  AXI burst length (beats−1), sampled at start.
- cfg_burst  in  2  AXI burst type, sampled at start.
- cfg_size  in  3  AXI beat size, sampled at start.
- cfg_base_addr  in  ADDRWIDTH  first-iteration address, sampled at start.
- link_online  in  1  AND of tx_online and rx_online.
- write_complete  in  1  pulse from leader app: write burst has finished.
- read_complete  in  1  pulse from follower app: read burst has finished.
- chkr_pass  in  2  pattern-checker result; [1] result valid, [0] 1=pass.
- aximm_wr  out  1  one-cycle write-command strobe.
- aximm_rd  out  1  one-cycle read-command strobe.
- aximm_rw_length  out  8  registered copy of cfg_length.
- aximm_rw_burst  out  2  registered copy of cfg_burst.
- aximm_rw_size  out  3  registered copy of cfg_size.
- aximm_rw_addr  out  ADDRWIDTH  current iteration address.
- busy  out  1  high from start acceptance until DONE is reached.
- done  out  1  one-cycle pulse when a run ends (normal end or abort).
- pass_cnt  out  8  passing iterations in the current or last run.
- fail_cnt  out  8  failing iterations in the current or last run.
- timeout_err  out  1  sticky flag; cleared by the next accepted start.
- state_dbg  out  3  current FSM state encoding.

## Operation
- States and encodings: IDLE=0, WAIT_ONL=1, WR_ISSUE=2, WR_WAIT=3, RD_ISSUE=4, RD_WAIT=5, CHECK=6, DONE=7.
- IDLE, start=1:
  - Latch all cfg_* inputs.
  - aximm_rw_addr←cfg_base_addr; iteration counter←0; pass_cnt, fail_cnt, timeout_err←0.
  - busy←1.
  - If cfg_num_iter==0, go to DONE; otherwise go to WAIT_ONL.
- WAIT_ONL: go to WR_ISSUE when link_online=1.
- WR_ISSUE: aximm_wr=1 for exactly this cycle; go to WR_WAIT.
- WR_WAIT: go to RD_ISSUE on write_complete.
- RD_ISSUE: aximm_rd=1 for exactly this cycle; go to RD_WAIT.
- RD_WAIT: go to CHECK on read_complete.
- CHECK: on chkr_pass[1]=1:
  - Increment pass_cnt if chkr_pass[0]=1, otherwise increment fail_cnt.
  - aximm_rw_addr += ADDR_STEP, modulo 2^ADDRWIDTH (wraps silently).
  - Increment the iteration counter.
  - If the counter now equals cfg_num_iter, go to DONE; otherwise go to WAIT_ONL.
- DONE: done=1 for one cycle; busy←0; go to IDLE.
- Timeout:
  - One counter, reset to 0 on entry to each of WAIT_ONL, WR_WAIT, RD_WAIT, CHECK.
  - Reaching TIMEOUT−1 without the exit condition: timeout_err←1, fail_cnt+1, go to DONE (abort the remainder of the run).
- link_online dropping in any state after WAIT_ONL: not monitored; the timeout covers it.
- pass_cnt and fail_cnt saturate at 255.
- Stray write_complete, read_complete or chkr_pass outside their consuming state: ignored.
- start while busy: ignored; no restart and no counter effect.

## Timing
- Reset values:
  - State IDLE.
  - aximm_wr, aximm_rd, busy, done, timeout_err = 0.
  - pass_cnt, fail_cnt = 0.
  - aximm_rw_length, aximm_rw_burst, aximm_rw_size, aximm_rw_addr = 0.
  - state_dbg = 0.
- All outputs are registered; no combinational input→output paths.
- Latencies:
  - start at cycle T: busy=1 at T+1, state WAIT_ONL at T+1.
  - link_online already high: aximm_wr=1 at T+2.
  - write_complete at cycle W: aximm_rd=1 at W+2.
  - chkr_pass valid at cycle C: counter update and new address visible at C+1.
  - Minimum gap between iterations is 2 cycles.
- aximm_rw_* are stable from the cycle before aximm_wr through the end of CHECK.
- Asserting rst mid-run: all outputs return to reset values immediately, without waiting for a clock edge. In-flight completions arriving after reset release are ignored because the FSM is in IDLE.

## Test plan
- Nominal run:
  - Stimulus: cfg_num_iter=3, base=0x1000, link_online=1; write_complete 5 cycles after each aximm_wr, read_complete 5 cycles after each aximm_rd, chkr_pass=2'b11.
  - Required: addresses 0x1000, 0x1100, 0x1200; pass_cnt=3, fail_cnt=0; one done pulse; busy low afterwards.
- Mixed verdicts:
  - Stimulus: 4 iterations with chkr_pass = 11, 10, 11, 10.
  - Required: pass_cnt=2, fail_cnt=2, timeout_err=0.
- Timeout:
  - Stimulus: TIMEOUT=16; read_complete never asserted on iteration 1 of 2.
  - Required: timeout_err=1, fail_cnt=1, pass_cnt=0; done exactly 15 cycles after RD_WAIT entry; no second aximm_wr.
- Edge cases:
  - cfg_num_iter=0 → done at T+1; no aximm_wr or aximm_rd strobes.
  - base=0xFFFF_FF80, 2 iterations → second address is 0x0000_0080 (wrap).
- Gating and ignored start:
  - Stimulus: link_online=0 for 50 cycles, then 1.
  - Required: aximm_wr appears 1 cycle after link_online rises.
  - Stimulus: start pulsed while busy.
  - Required: no change to counters or to the sequence.
- Reset mid-run:
  - Stimulus: assert rst during WR_WAIT.
  - Required: all outputs at reset values immediately; a write_complete after release causes no state change.
